// File: rtl/imp_sweep_seq_pkg.sv
// Shared types and constants for the impedance frequency-sweep sequencer.
package imp_sweep_pkg;

    // Sequencer states, one per phase of a frequency point.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        MEAS   = 3'd2,
        ACQ_I  = 3'd3,
        ACQ_Q  = 3'd4,
        NEXT   = 3'd5,
        DONE   = 3'd6
    } sweep_state_e;

    // StepNum encodings understood by the DAC controller.
    localparam logic STEPS_32 = 1'b0;
    localparam logic STEPS_16 = 1'b1;

    // States in which the DAC is running and receives step strobes.
    function automatic logic is_strobing(sweep_state_e s);
        return (s == SETTLE) || (s == MEAS) || (s == ACQ_I) || (s == ACQ_Q);
    endfunction

endpackage

// File: rtl/imp_sweep_seq_if.sv
// DAC-controller and ADC front-end pins driven/observed by the sequencer.
interface imp_sweep_if;

    // DAC controller side
    logic CountEnable;
    logic StepNum;
    logic DacResetn;
    logic IP;

    // ADC front-end side
    logic AdcReady;
    logic AdcDone;
    logic AdcStartI;
    logic AdcStartQ;

    // Sequencer view
    modport master (
        output CountEnable, StepNum, DacResetn, AdcStartI, AdcStartQ,
        input  IP, AdcReady, AdcDone
    );

    // DAC controller / ADC view
    modport slave (
        input  CountEnable, StepNum, DacResetn, AdcStartI, AdcStartQ,
        output IP, AdcReady, AdcDone
    );

endinterface

// File: rtl/imp_sweep_seq_step_div.sv
// Loadable down-counter: ticks when it reaches zero, then reloads to div,
// so the tick repeats every div+1 cycles. clr parks it at zero so the very
// next enabled cycle ticks immediately.
module imp_step_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // Next count: park at zero when cleared, reload on tick, else count down.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == '0) begin
            cnt_d = div;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/imp_sweep_seq.sv
// Frequency-sweep sequencer: steps the DAC controller through NumPoints+1
// frequency points (divider halves each point), settles and measures on IP
// periods, then runs an I-then-Q ADC acquisition handshake per point.
module imp_sweep_seq
    import imp_sweep_pkg::*;
#(
    parameter int NPTS_W = 4,
    parameter int DIV_W  = 8,
    parameter int PER_W  = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Abort,
    input  logic [NPTS_W-1:0] NumPoints,
    input  logic [DIV_W-1:0]  DivBase,
    input  logic [PER_W-1:0]  SettlePeriods,
    input  logic [PER_W-1:0]  MeasPeriods,
    input  logic              StepMode,
    imp_sweep_if.master       bus,
    output logic [NPTS_W-1:0] PointIdx,
    output logic              Busy,
    output logic              Done
);

    sweep_state_e      state_q, state_d;
    logic [NPTS_W-1:0] point_idx_q, point_idx_d;
    logic [NPTS_W-1:0] cfg_npts_q, cfg_npts_d;
    logic [DIV_W-1:0]  cfg_div_q, cfg_div_d;
    logic [PER_W-1:0]  cfg_settle_q, cfg_settle_d;
    logic [PER_W-1:0]  cfg_meas_q, cfg_meas_d;
    logic              cfg_step_q, cfg_step_d;
    logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
    logic              ip_q;
    logic              issued_q, issued_d;
    logic              start_i_q, start_i_d;
    logic              start_q_q, start_q_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dac_resetn_q, dac_resetn_d;

    logic              ip_rise;
    logic [PER_W-1:0]  meas_target;
    logic [DIV_W-1:0]  div_cur;
    logic              strobing;
    logic              div_tick;

    assign ip_rise     = bus.IP & ~ip_q;
    assign meas_target = (cfg_meas_q == '0) ? PER_W'(1) : cfg_meas_q;
    assign div_cur     = cfg_div_q >> point_idx_q;
    assign strobing    = is_strobing(state_q);

    // Step divider; held at zero outside strobing states so each point's
    // first strobe lands on the first cycle of SETTLE.
    imp_step_div #(
        .DIV_W (DIV_W)
    ) u_step_div (
        .clk  (Clk),
        .srst (Reset),
        .clr  (~strobing),
        .div  (div_cur),
        .tick (div_tick)
    );

    // Next-state, config latch, handshake and registered-output decode.
    always_comb begin
        state_d      = state_q;
        point_idx_d  = point_idx_q;
        cfg_npts_d   = cfg_npts_q;
        cfg_div_d    = cfg_div_q;
        cfg_settle_d = cfg_settle_q;
        cfg_meas_d   = cfg_meas_q;
        cfg_step_d   = cfg_step_q;
        issued_d     = issued_q;
        start_i_d    = 1'b0;
        start_q_d    = 1'b0;
        per_cnt_d    = per_cnt_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d      = SETTLE;
                    point_idx_d  = '0;
                    cfg_npts_d   = NumPoints;
                    cfg_div_d    = DivBase;
                    cfg_settle_d = SettlePeriods;
                    cfg_meas_d   = MeasPeriods;
                    cfg_step_d   = StepMode;
                end
            end
            SETTLE: begin
                if (per_cnt_q >= cfg_settle_q) begin
                    state_d = MEAS;
                end
            end
            MEAS: begin
                if (per_cnt_q >= meas_target) begin
                    state_d = ACQ_I;
                end
            end
            ACQ_I: begin
                if (!issued_q) begin
                    if (bus.AdcReady) begin
                        start_i_d = 1'b1;
                        issued_d  = 1'b1;
                    end
                end else if (bus.AdcDone) begin
                    state_d = ACQ_Q;
                end
            end
            ACQ_Q: begin
                if (!issued_q) begin
                    if (bus.AdcReady) begin
                        start_q_d = 1'b1;
                        issued_d  = 1'b1;
                    end
                end else if (bus.AdcDone) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (point_idx_q == cfg_npts_q) begin
                    state_d = DONE;
                end else begin
                    point_idx_d = point_idx_q + NPTS_W'(1);
                    state_d     = SETTLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything: back to IDLE, nothing latched, index held.
        if (Abort) begin
            state_d      = IDLE;
            point_idx_d  = point_idx_q;
            cfg_npts_d   = cfg_npts_q;
            cfg_div_d    = cfg_div_q;
            cfg_settle_d = cfg_settle_q;
            cfg_meas_d   = cfg_meas_q;
            cfg_step_d   = cfg_step_q;
            start_i_d    = 1'b0;
            start_q_d    = 1'b0;
        end

        // Period counter and issue flag restart on every state entry;
        // the counter saturates instead of wrapping.
        if (state_d != state_q) begin
            per_cnt_d = '0;
            issued_d  = 1'b0;
        end else if (ip_rise && (per_cnt_q != '1)) begin
            per_cnt_d = per_cnt_q + PER_W'(1);
        end

        busy_d       = (state_d != IDLE) && (state_d != DONE);
        done_d       = (state_d == DONE);
        dac_resetn_d = is_strobing(state_d);
    end

    // State, configuration and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            point_idx_q  <= '0;
            cfg_npts_q   <= '0;
            cfg_div_q    <= '0;
            cfg_settle_q <= '0;
            cfg_meas_q   <= '0;
            cfg_step_q   <= STEPS_32;
            per_cnt_q    <= '0;
            ip_q         <= 1'b0;
            issued_q     <= 1'b0;
            start_i_q    <= 1'b0;
            start_q_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dac_resetn_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            point_idx_q  <= point_idx_d;
            cfg_npts_q   <= cfg_npts_d;
            cfg_div_q    <= cfg_div_d;
            cfg_settle_q <= cfg_settle_d;
            cfg_meas_q   <= cfg_meas_d;
            cfg_step_q   <= cfg_step_d;
            per_cnt_q    <= per_cnt_d;
            ip_q         <= bus.IP;
            issued_q     <= issued_d;
            start_i_q    <= start_i_d;
            start_q_q    <= start_q_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            dac_resetn_q <= dac_resetn_d;
        end
    end

    // CountEnable is the only combinational output: divider tick gated by state.
    assign bus.CountEnable = div_tick & strobing;
    assign bus.StepNum     = cfg_step_q;
    assign bus.DacResetn   = dac_resetn_q;
    assign bus.AdcStartI   = start_i_q;
    assign bus.AdcStartQ   = start_q_q;
    assign PointIdx        = point_idx_q;
    assign Busy            = busy_q;
    assign Done            = done_q;

endmodule

// File: tb/tb_imp_sweep_seq.sv
// Self-checking bench for imp_sweep_seq: ADC/Done events are checked against
// an expected-event queue; strobe spacing, boundaries, abort and reset are
// checked directly.
module tb_imp_sweep_seq;

    logic       Clk = 1'b0;
    logic       Reset, Start, Abort;
    logic [3:0] NumPoints;
    logic [7:0] DivBase, SettlePeriods, MeasPeriods;
    logic       StepMode;
    logic [3:0] PointIdx;
    logic       Busy, Done;

    imp_sweep_if sweep_if ();

    imp_sweep_seq #(
        .NPTS_W (4),
        .DIV_W  (8),
        .PER_W  (8)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Start         (Start),
        .Abort         (Abort),
        .NumPoints     (NumPoints),
        .DivBase       (DivBase),
        .SettlePeriods (SettlePeriods),
        .MeasPeriods   (MeasPeriods),
        .StepMode      (StepMode),
        .bus           (sweep_if),
        .PointIdx      (PointIdx),
        .Busy          (Busy),
        .Done          (Done)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        byte kind;
        int  pt;
    } evt_t;
    evt_t sb[$];
    int ev_i = 0, ev_q = 0, ev_d = 0;

    task automatic push_sweep(input int npts);
        for (int p = 0; p <= npts; p++) begin
            sb.push_back('{kind: "I", pt: p});
            sb.push_back('{kind: "Q", pt: p});
        end
        sb.push_back('{kind: "D", pt: npts});
    endtask

    task automatic sb_pop(input byte kind);
        evt_t e;
        $display("EVT %c pt=%0d t=%0t", kind, PointIdx, $time);
        if (sb.size() == 0) begin
            chk("sb_unexpected", kind, 0);
        end else begin
            e = sb.pop_front();
            chk("sb_kind", kind, e.kind);
            chk("sb_pt", PointIdx, e.pt);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge Clk) begin
        if (!Reset) begin
            if (sweep_if.AdcStartI) begin sb_pop("I"); ev_i++; end
            if (sweep_if.AdcStartQ) begin sb_pop("Q"); ev_q++; end
            if (Done)               begin sb_pop("D"); ev_d++; end
        end
    end

    // ---------------- IP source and ADC model ----------------
    logic ip_auto = 1'b1, ip_manual = 1'b0, stray_done = 1'b0;
    int   ip_phase = 0, adc_timer = 0;
    logic done_now;

    always begin
        @(posedge Clk);
        #1;
        ip_phase = (ip_phase + 1) % 8;
        sweep_if.IP = ip_auto ? (ip_phase < 4) : ip_manual;
        done_now = 1'b0;
        if (adc_timer > 0) begin
            adc_timer--;
            if (adc_timer == 0) done_now = 1'b1;
        end
        if (sweep_if.AdcStartI || sweep_if.AdcStartQ) adc_timer = 3;
        sweep_if.AdcDone = done_now | stray_done;
    end

    // ---------------- sweep runner ----------------
    task automatic run_sweep(input int npts, input int div, input int settle, input int meas,
                             input logic mode, input int inject_pt,
                             output int gap_err, output int rn_low, output int gaps_seen,
                             output int ok_end);
        int   last_cyc, last_pt;
        logic have_last, injected, done_seen;
        gap_err = 0; rn_low = 0; gaps_seen = 0; ok_end = 0;
        have_last = 0; injected = 0; done_seen = 0; last_cyc = 0; last_pt = 0;
        push_sweep(npts);
        NumPoints = 4'(npts); DivBase = 8'(div);
        SettlePeriods = 8'(settle); MeasPeriods = 8'(meas); StepMode = mode;
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        chk("first_cycle_busy_rn_ce", {Busy, sweep_if.DacResetn, sweep_if.CountEnable}, 3'b111);
        chk("step_num", sweep_if.StepNum, mode);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (Done) done_seen = 1'b1;
            if (Busy && !sweep_if.DacResetn) rn_low++;
            if (!sweep_if.DacResetn) begin
                have_last = 1'b0;
            end else if (sweep_if.CountEnable) begin
                if (have_last && (int'(PointIdx) == last_pt)) begin
                    gaps_seen++;
                    if (cyc - last_cyc != (div >> PointIdx) + 1) gap_err++;
                end
                have_last = 1'b1; last_cyc = cyc; last_pt = int'(PointIdx);
            end
            if (inject_pt >= 0 && !injected && int'(PointIdx) == inject_pt && Busy) begin
                Start = 1'b1; NumPoints = 4'd0; DivBase = 8'd0; StepMode = ~mode;
                SettlePeriods = 8'd0; MeasPeriods = 8'd0; injected = 1'b1;
            end else begin
                Start = 1'b0;
            end
            if (done_seen && !Busy) begin
                ok_end = 1;
                break;
            end
            @(negedge Clk);
        end
        Start = 1'b0;
        @(negedge Clk);
    endtask

    int gap_err, rn_low, gaps_seen, ok_end;
    int si, sq, sd, cnt_i, cnt_q, lat, cnt_done, found;
    logic acc;

    initial begin
        Reset = 1'b1; Start = 1'b0; Abort = 1'b0;
        NumPoints = '0; DivBase = '0; SettlePeriods = '0; MeasPeriods = '0; StepMode = 1'b0;
        sweep_if.AdcReady = 1'b1;
        repeat (3) @(negedge Clk);
        chk("reset_outputs", {Busy, Done, sweep_if.DacResetn, sweep_if.StepNum,
            sweep_if.CountEnable, sweep_if.AdcStartI, sweep_if.AdcStartQ, PointIdx}, 0);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        chk("idle_after_reset_busy", Busy, 0);

        // Single point, DivBase=0: strobe continuously high, one I, one Q, one Done.
        si = ev_i; sq = ev_q; sd = ev_d;
        run_sweep(0, 0, 1, 2, 1'b1, -1, gap_err, rn_low, gaps_seen, ok_end);
        chk("t1_completed", ok_end, 1);
        chk("t1_ce_continuous", gap_err, 0);
        chk("t1_gaps_seen", gaps_seen > 0, 1);
        chk("t1_rn_low", rn_low, 1);
        chk("t1_num_i", ev_i - si, 1);
        chk("t1_num_q", ev_q - sq, 1);
        chk("t1_num_done", ev_d - sd, 1);
        chk("t1_busy_after", {Busy, Done}, 0);
        repeat (10) @(negedge Clk);

        // Divider scaling 4/2/1, plus a Start with new config mid-sweep that must be ignored.
        si = ev_i; sq = ev_q; sd = ev_d;
        run_sweep(2, 3, 1, 1, 1'b0, 1, gap_err, rn_low, gaps_seen, ok_end);
        chk("t2_completed", ok_end, 1);
        chk("t2_gap_err", gap_err, 0);
        chk("t2_gaps_seen", gaps_seen > 2, 1);
        chk("t2_rn_low", rn_low, 3);
        chk("t2_num_i", ev_i - si, 3);
        chk("t2_num_q", ev_q - sq, 3);
        chk("t2_num_done", ev_d - sd, 1);
        chk("t2_step_num_kept", sweep_if.StepNum, 0);
        chk("t2_point_idx_end", PointIdx, 2);
        repeat (10) @(negedge Clk);

        // Boundary periods: Settle=0 leaves at once, Meas=0 waits for one IP rise.
        ip_auto = 1'b0; ip_manual = 1'b0;
        repeat (4) @(negedge Clk);
        push_sweep(0);
        NumPoints = 4'd0; DivBase = 8'd1; SettlePeriods = 8'd0; MeasPeriods = 8'd0; StepMode = 1'b0;
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        cnt_i = 0;
        repeat (6) begin
            if (sweep_if.AdcStartI) cnt_i++;
            @(negedge Clk);
        end
        chk("t3_no_acq_without_rise", cnt_i, 0);
        ip_manual = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            if (sweep_if.AdcStartI) begin lat = k; break; end
        end
        $display("INFO t3 IP-rise to AdcStartI latency %0d", lat);
        chk("t3_meas_ends_first_rise", (lat >= 3 && lat <= 5), 1);
        found = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge Clk);
            if (Done) begin found = 1; break; end
        end
        chk("t3_done", found, 1);
        repeat (10) @(negedge Clk);

        // Handshake stall with stray AdcDone pulses before the I start is issued.
        ip_manual = 1'b0;
        sweep_if.AdcReady = 1'b0;
        repeat (3) @(negedge Clk);
        push_sweep(0);
        NumPoints = 4'd0; DivBase = 8'd2; SettlePeriods = 8'd0; MeasPeriods = 8'd1; StepMode = 1'b1;
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        repeat (2) @(negedge Clk);
        stray_done = 1'b1;
        @(negedge Clk); stray_done = 1'b0;
        @(negedge Clk); ip_manual = 1'b1;
        cnt_i = 0; cnt_q = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge Clk);
            if (sweep_if.AdcStartI) cnt_i++;
            if (sweep_if.AdcStartQ) cnt_q++;
            stray_done = (k == 8);
        end
        stray_done = 1'b0;
        chk("t4_no_start_i_stall", cnt_i, 0);
        chk("t4_no_start_q_stall", cnt_q, 0);
        chk("t4_busy_stall", Busy, 1);
        sweep_if.AdcReady = 1'b1;
        cnt_i = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            if (sweep_if.AdcStartI) cnt_i++;
        end
        chk("t4_one_start_i", cnt_i, 1);
        found = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge Clk);
            if (Done) begin found = 1; break; end
        end
        chk("t4_done", found, 1);
        ip_auto = 1'b1;
        repeat (10) @(negedge Clk);

        // Abort during MEAS at point 1.
        push_sweep(3);
        NumPoints = 4'd3; DivBase = 8'd2; SettlePeriods = 8'd1; MeasPeriods = 8'd3; StepMode = 1'b0;
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        found = 0;
        for (int k = 0; k < 300; k++) begin
            if (PointIdx == 4'd1) begin found = 1; break; end
            @(negedge Clk);
        end
        chk("t5_reach_point1", found, 1);
        repeat (14) @(negedge Clk);
        chk("t5_sb_left", sb.size(), 7);
        Abort = 1'b1;
        @(negedge Clk); Abort = 1'b0;
        sb.delete();
        chk("t5_after_abort", {Busy, sweep_if.CountEnable, sweep_if.DacResetn,
            sweep_if.AdcStartI, sweep_if.AdcStartQ, Done}, 0);
        chk("t5_point_idx_held", PointIdx, 1);
        cnt_done = 0;
        repeat (30) begin
            @(negedge Clk);
            if (Done || Busy) cnt_done++;
        end
        chk("t5_no_done_no_busy", cnt_done, 0);

        // Start and Abort together in IDLE: no sweep.
        @(negedge Clk); Start = 1'b1; Abort = 1'b1;
        @(negedge Clk); Start = 1'b0; Abort = 1'b0;
        acc = 1'b0;
        repeat (5) begin
            acc = acc | Busy | sweep_if.DacResetn;
            @(negedge Clk);
        end
        chk("t5_start_abort_collision", acc, 0);

        // Reset mid-sweep at point 1.
        push_sweep(2);
        NumPoints = 4'd2; DivBase = 8'd0; SettlePeriods = 8'd0; MeasPeriods = 8'd1; StepMode = 1'b1;
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        found = 0;
        for (int k = 0; k < 300; k++) begin
            if (PointIdx == 4'd1) begin found = 1; break; end
            @(negedge Clk);
        end
        chk("t6_reach_point1", found, 1);
        @(negedge Clk);
        Reset = 1'b1;
        sb.delete();
        @(negedge Clk);
        chk("t6_reset_outputs", {Busy, Done, sweep_if.DacResetn, sweep_if.StepNum,
            sweep_if.CountEnable, sweep_if.AdcStartI, sweep_if.AdcStartQ, PointIdx}, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        acc = 1'b0;
        repeat (5) begin
            @(negedge Clk);
            acc = acc | Busy;
        end
        chk("t6_busy_after_release", acc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
